rob_wide: RTL and testbench
===========================

# rob_wide

Parametrised reorder buffer, the successor to the single-writeback ROB.
- Sits between the dispatcher, the reservation stations/ALUs/LSB (result buses), the register file and the branch predictor.
- Allocates entries in program order and accepts results from `NUM_WB` writeback channels.
- Forwards operand values to the dispatcher, retires one entry per cycle in order, and on a mispredicted branch flushes the whole window and redirects fetch.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, ≥2.
- `XLEN`, 32: data/address width.
- `NUM_WB`, 2: number of writeback channels.
- `TAGW`, `$clog2(DEPTH)`: tag width (derived; do not override).

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, asynchronous and active-low.
- `rdy_in` in 1: global enable; low freezes all state.
- `alloc_valid_in` in 1: dispatcher requests an entry.
- `alloc_ready_out` out 1: entry can be accepted. Combinational: `!full && !flush_out`.
- `alloc_rd_in` in 5: destination register; 0 means no writeback.
- `alloc_is_branch_in` in 1: entry is a conditional branch or jalr.
- `alloc_is_store_in` in 1: entry is a store.
- `alloc_pred_taken_in` in 1: predictor's direction.
- `alloc_pc_in` in XLEN: instruction PC.
- `alloc_rollback_pc_in` in XLEN: fetch redirect target if the prediction is wrong.
- `alloc_tag_out` out TAGW: tag assigned to the request. Combinational, equal to the tail index.
- `q1_tag_in`, `q2_tag_in` in TAGW: operand tags to look up.
- `q1_ready_out`, `q2_ready_out` out 1: operand value available.
- `q1_data_out`, `q2_data_out` out XLEN: operand value.
- `wb_valid_in` in NUM_WB: per-channel result valid.
- `wb_tag_in` in NUM_WB*TAGW: per-channel tag, packed; channel i at `[i*TAGW +: TAGW]`.
- `wb_data_in` in NUM_WB*XLEN: per-channel result, packed the same way.
- `wb_taken_in` in NUM_WB: actual branch direction; meaningful for branches only.
- `commit_valid_out` out 1: one-cycle pulse, an entry retired.
- `commit_rd_out` out 5: destination register of the retired entry.
- `commit_data_out` out XLEN: result of the retired entry.
- `commit_tag_out` out TAGW: tag of the retired entry.
- `commit_store_out` out 1: retired entry is a store; the LSB may perform it.
- `flush_out` out 1: one-cycle pulse, mispredict flush.
- `flush_pc_out` out XLEN: redirect PC, valid with `flush_out`.
- `pred_valid_out` out 1: one-cycle pulse, predictor update.
- `pred_taken_out` out 1: actual direction of the retired branch.
- `pred_pc_out` out XLEN: PC of the retired branch.
- `empty_out` out 1: no valid entries.
- `count_out` out TAGW+1: number of valid entries.

## Operation
- Storage is a circular buffer.
  - `head`/`tail` pointers are TAGW bits and wrap modulo DEPTH.
  - A `count` register of TAGW+1 bits sets full = (`count == DEPTH`).
  - Each entry holds busy, ready, rd, is_branch, is_store, pred_taken, taken, pc, rollback_pc and data.
- Allocate: on an edge with `alloc_valid_in && alloc_ready_out && rdy_in`:
  - write the entry at `tail`, with busy=1 and ready=0;
  - advance `tail`.
- Writeback: for each channel with `wb_valid_in[i]` whose tagged entry is busy, set ready=1 and store data and taken.
  - A writeback to a non-busy entry is ignored.
  - If two channels carry the same tag in one cycle, the lower index wins.
- Query, combinational, per operand, in priority order:
  - the lowest-index writeback channel matching the tag this cycle gives ready=1 and that channel's data;
  - otherwise the entry's registered ready bit and data.
  - The result for a non-busy tag is don't-care; the dispatcher only queries busy tags.
- Commit: the head entry retires when it is busy and ready (registered bit).
  - It clears busy and advances `head`.
  - It registers all `commit_*` outputs for one cycle. `commit_store_out` = is_store.
  - If is_branch: `pred_valid_out`=1, `pred_taken_out`=taken, `pred_pc_out`=pc.
  - If is_branch and taken≠pred_taken:
    - `flush_out`=1 and `flush_pc_out`=rollback_pc;
    - on the same edge, every busy bit clears, head=tail=0 and count=0;
    - an allocation attempted on that edge is dropped.
- `count` update: +1 on allocate, −1 on commit, unchanged when both occur. A flush overrides both to 0.

## Timing
- Reset (rst_in=0, asynchronous): all registers and registered outputs are 0.
  - Resulting combinational outputs: `alloc_ready_out`=1, `empty_out`=1, `alloc_tag_out`=0.
- `rdy_in`=0: no allocate, writeback or commit takes effect. The pulse outputs `commit_valid_out`, `flush_out` and `pred_valid_out` are forced to 0 at that edge; all other state holds.
- Latency:
  - Allocate at edge N: the tag is visible before N; the entry is busy after N.
  - Writeback at edge N: query forwarding in the same cycle as `wb_valid_in`.
  - Earliest commit of that entry is edge N+1, so `commit_valid_out` is high in cycle N+1..N+2.
- Full: `alloc_ready_out` is low even if the head commits this cycle; no same-cycle alloc-on-free.
- Empty: allocate and commit never coincide on the same entry, because a fresh entry is never ready.
- `alloc_ready_out` is 0 during the cycle `flush_out` is high.

## Test plan
- Reset mid-operation: fill 5 entries, drop rst_in asynchronously → count_out=0, empty_out=1, all pulses 0 immediately, with no clock edge needed.
- Fill/wrap, DEPTH=4: allocate 4 → alloc_ready_out=0, count_out=4.
  - Write back tags 0..3 → commits in order, with commit_tag_out 0,1,2,3 on consecutive cycles.
  - Then allocate 2 more → tags 0,1 (wrap).
- Out-of-order writeback: allocate tags 0,1,2; write back 2, then 1, then 0 → no commit until tag 0 is ready, then 3 commits on consecutive cycles.
- Forwarding and priority: wb channels 0 and 1 both carry tag 3, data 0xAA and 0xBB, with q1_tag_in=3 → q1_ready_out=1, q1_data_out=0xAA, and entry data 0xAA.
- Mispredict:
  - allocate branch (pred_taken=0, rollback_pc=0x1000, pc=0x0F00) plus 3 younger entries;
  - write back the branch with taken=1 → at commit: flush_out=1, flush_pc_out=0x1000, pred_valid_out=1, pred_pc_out=0x0F00;
  - next cycle count_out=0; an allocation on the flush edge is not recorded.
- rdy_in stall: a ready head with rdy_in=0 for 3 cycles → no commit pulse; it commits on the first edge after rdy_in=1.

Source files
------------

// File: rtl/rob_wide.sv
// Reorder buffer with NUM_WB writeback channels. Allocates in order, forwards operands,
// retires one entry per cycle and flushes the whole window on a mispredicted branch.
module rob_wide #(
    parameter int DEPTH  = 16,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2,
    parameter int TAGW   = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     alloc_valid_in,
    output logic                     alloc_ready_out,
    input  logic [4:0]               alloc_rd_in,
    input  logic                     alloc_is_branch_in,
    input  logic                     alloc_is_store_in,
    input  logic                     alloc_pred_taken_in,
    input  logic [XLEN-1:0]          alloc_pc_in,
    input  logic [XLEN-1:0]          alloc_rollback_pc_in,
    output logic [TAGW-1:0]          alloc_tag_out,
    input  logic [TAGW-1:0]          q1_tag_in,
    input  logic [TAGW-1:0]          q2_tag_in,
    output logic                     q1_ready_out,
    output logic                     q2_ready_out,
    output logic [XLEN-1:0]          q1_data_out,
    output logic [XLEN-1:0]          q2_data_out,
    input  logic [NUM_WB-1:0]        wb_valid_in,
    input  logic [NUM_WB*TAGW-1:0]   wb_tag_in,
    input  logic [NUM_WB*XLEN-1:0]   wb_data_in,
    input  logic [NUM_WB-1:0]        wb_taken_in,
    output logic                     commit_valid_out,
    output logic [4:0]               commit_rd_out,
    output logic [XLEN-1:0]          commit_data_out,
    output logic [TAGW-1:0]          commit_tag_out,
    output logic                     commit_store_out,
    output logic                     flush_out,
    output logic [XLEN-1:0]          flush_pc_out,
    output logic                     pred_valid_out,
    output logic                     pred_taken_out,
    output logic [XLEN-1:0]          pred_pc_out,
    output logic                     empty_out,
    output logic [TAGW:0]            count_out
);

    logic [TAGW-1:0]  r_head, r_tail;
    logic [TAGW:0]    r_count;
    logic [DEPTH-1:0] r_busy, r_ready, r_is_branch, r_is_store, r_pred_taken, r_taken;
    logic [4:0]       r_rd     [DEPTH];
    logic [XLEN-1:0]  r_pc     [DEPTH];
    logic [XLEN-1:0]  r_rb_pc  [DEPTH];
    logic [XLEN-1:0]  r_data   [DEPTH];

    logic             r_commit_valid, r_commit_store, r_flush, r_pred_valid, r_pred_taken_o;
    logic [4:0]       r_commit_rd;
    logic [XLEN-1:0]  r_commit_data, r_flush_pc, r_pred_pc;
    logic [TAGW-1:0]  r_commit_tag;

    logic             w_full, w_alloc, w_commit, w_mispredict, w_head_branch;
    logic [DEPTH-1:0] w_wb_hit, w_wb_taken;
    logic [XLEN-1:0]  w_wb_data [DEPTH];

    assign w_full          = (r_count == (TAGW+1)'(DEPTH));
    assign alloc_ready_out = !w_full && !r_flush;
    assign alloc_tag_out   = r_tail;
    assign empty_out       = (r_count == '0);
    assign count_out       = r_count;

    assign w_head_branch = r_is_branch[r_head];
    assign w_commit      = rdy_in && r_busy[r_head] && r_ready[r_head];
    assign w_mispredict  = w_commit && w_head_branch && (r_taken[r_head] != r_pred_taken[r_head]);
    // An allocation on the flush edge is dropped.
    assign w_alloc       = alloc_valid_in && alloc_ready_out && rdy_in && !w_mispredict;

    // Per-entry writeback decode; walking channels downward lets the lowest index win.
    always_comb begin
        w_wb_hit   = '0;
        w_wb_taken = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wb_data[e] = '0;
            for (int c = NUM_WB - 1; c >= 0; c--) begin
                if (wb_valid_in[c] && wb_tag_in[c*TAGW +: TAGW] == TAGW'(e)) begin
                    w_wb_hit[e]   = 1'b1;
                    w_wb_data[e]  = wb_data_in[c*XLEN +: XLEN];
                    w_wb_taken[e] = wb_taken_in[c];
                end
            end
        end
    end

    always_comb begin
        q1_ready_out = r_ready[q1_tag_in];
        q1_data_out  = r_data[q1_tag_in];
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (wb_valid_in[c] && wb_tag_in[c*TAGW +: TAGW] == q1_tag_in) begin
                q1_ready_out = 1'b1;
                q1_data_out  = wb_data_in[c*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        q2_ready_out = r_ready[q2_tag_in];
        q2_data_out  = r_data[q2_tag_in];
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (wb_valid_in[c] && wb_tag_in[c*TAGW +: TAGW] == q2_tag_in) begin
                q2_ready_out = 1'b1;
                q2_data_out  = wb_data_in[c*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_is_branch  <= '0;
            r_is_store   <= '0;
            r_pred_taken <= '0;
            r_taken      <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_rd[e]    <= '0;
                r_pc[e]    <= '0;
                r_rb_pc[e] <= '0;
                r_data[e]  <= '0;
            end
        end else if (rdy_in) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_mispredict) begin
                    r_busy[e] <= 1'b0;
                end else if (w_alloc && r_tail == TAGW'(e)) begin
                    r_busy[e]       <= 1'b1;
                    r_ready[e]      <= 1'b0;
                    r_taken[e]      <= 1'b0;
                    r_rd[e]         <= alloc_rd_in;
                    r_is_branch[e]  <= alloc_is_branch_in;
                    r_is_store[e]   <= alloc_is_store_in;
                    r_pred_taken[e] <= alloc_pred_taken_in;
                    r_pc[e]         <= alloc_pc_in;
                    r_rb_pc[e]      <= alloc_rollback_pc_in;
                end else begin
                    if (w_wb_hit[e] && r_busy[e]) begin
                        r_ready[e] <= 1'b1;
                        r_data[e]  <= w_wb_data[e];
                        r_taken[e] <= w_wb_taken[e];
                    end
                    if (w_commit && r_head == TAGW'(e)) begin
                        r_busy[e] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_commit) r_head <= r_head + TAGW'(1);
                if (w_alloc)  r_tail <= r_tail + TAGW'(1);
                unique case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + (TAGW+1)'(1);
                    2'b01:   r_count <= r_count - (TAGW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_commit_valid <= 1'b0;
            r_commit_store <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_commit_tag   <= '0;
            r_flush        <= 1'b0;
            r_flush_pc     <= '0;
            r_pred_valid   <= 1'b0;
            r_pred_taken_o <= 1'b0;
            r_pred_pc      <= '0;
        end else if (!rdy_in) begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
            r_pred_valid   <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            r_flush        <= w_mispredict;
            r_pred_valid   <= w_commit && w_head_branch;
            if (w_commit) begin
                r_commit_store <= r_is_store[r_head];
                r_commit_rd    <= r_rd[r_head];
                r_commit_data  <= r_data[r_head];
                r_commit_tag   <= r_head;
            end
            if (w_commit && w_head_branch) begin
                r_pred_taken_o <= r_taken[r_head];
                r_pred_pc      <= r_pc[r_head];
            end
            if (w_mispredict) begin
                r_flush_pc <= r_rb_pc[r_head];
            end
        end
    end

    assign commit_valid_out = r_commit_valid;
    assign commit_store_out = r_commit_store;
    assign commit_rd_out    = r_commit_rd;
    assign commit_data_out  = r_commit_data;
    assign commit_tag_out   = r_commit_tag;
    assign flush_out        = r_flush;
    assign flush_pc_out     = r_flush_pc;
    assign pred_valid_out   = r_pred_valid;
    assign pred_taken_out   = r_pred_taken_o;
    assign pred_pc_out      = r_pred_pc;

endmodule

// File: tb/tb_rob_wide.sv
// Directed bench for rob_wide: expected retirements are queued by the stimulus and
// checked by an independent commit monitor.
module tb_rob_wide;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int NWB   = 2;
    localparam int TW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, rdy;
    logic              a_valid, a_ready, a_br, a_st, a_pt;
    logic [4:0]        a_rd;
    logic [XLEN-1:0]   a_pc, a_rb;
    logic [TW-1:0]     a_tag, q1_tag, q2_tag;
    logic              q1_rdy, q2_rdy;
    logic [XLEN-1:0]   q1_data, q2_data;
    logic [NWB-1:0]    wb_v, wb_k;
    logic [NWB*TW-1:0] wb_t;
    logic [NWB*XLEN-1:0] wb_d;
    logic              c_valid, c_store, fl, p_valid, p_taken, empty;
    logic [4:0]        c_rd;
    logic [XLEN-1:0]   c_data, fl_pc, p_pc;
    logic [TW-1:0]     c_tag;
    logic [TW:0]       count;

    // Second, deeper instance used only for the asynchronous reset scenario.
    logic              b_rst_n, b_valid, b_ready, b_q1_rdy, b_q2_rdy;
    logic [2:0]        b_tag, b_q_tag, b_c_tag;
    logic [XLEN-1:0]   b_q1_data, b_q2_data, b_c_data, b_fl_pc, b_p_pc;
    logic [NWB-1:0]    b_wb_v;
    logic [NWB*3-1:0]  b_wb_t;
    logic              b_c_valid, b_c_store, b_fl, b_p_valid, b_p_taken, b_empty;
    logic [4:0]        b_c_rd;
    logic [3:0]        b_count;

    rob_wide #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_WB(NWB)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .alloc_valid_in(a_valid), .alloc_ready_out(a_ready), .alloc_rd_in(a_rd),
        .alloc_is_branch_in(a_br), .alloc_is_store_in(a_st), .alloc_pred_taken_in(a_pt),
        .alloc_pc_in(a_pc), .alloc_rollback_pc_in(a_rb), .alloc_tag_out(a_tag),
        .q1_tag_in(q1_tag), .q2_tag_in(q2_tag), .q1_ready_out(q1_rdy), .q2_ready_out(q2_rdy),
        .q1_data_out(q1_data), .q2_data_out(q2_data),
        .wb_valid_in(wb_v), .wb_tag_in(wb_t), .wb_data_in(wb_d), .wb_taken_in(wb_k),
        .commit_valid_out(c_valid), .commit_rd_out(c_rd), .commit_data_out(c_data),
        .commit_tag_out(c_tag), .commit_store_out(c_store), .flush_out(fl),
        .flush_pc_out(fl_pc), .pred_valid_out(p_valid), .pred_taken_out(p_taken),
        .pred_pc_out(p_pc), .empty_out(empty), .count_out(count)
    );

    rob_wide #(.DEPTH(8), .XLEN(XLEN), .NUM_WB(NWB)) u_big (
        .clk_in(clk), .rst_in(b_rst_n), .rdy_in(rdy),
        .alloc_valid_in(b_valid), .alloc_ready_out(b_ready), .alloc_rd_in(a_rd),
        .alloc_is_branch_in(a_br), .alloc_is_store_in(a_st), .alloc_pred_taken_in(a_pt),
        .alloc_pc_in(a_pc), .alloc_rollback_pc_in(a_rb), .alloc_tag_out(b_tag),
        .q1_tag_in(b_q_tag), .q2_tag_in(b_q_tag), .q1_ready_out(b_q1_rdy),
        .q2_ready_out(b_q2_rdy), .q1_data_out(b_q1_data), .q2_data_out(b_q2_data),
        .wb_valid_in(b_wb_v), .wb_tag_in(b_wb_t), .wb_data_in(wb_d), .wb_taken_in(wb_k),
        .commit_valid_out(b_c_valid), .commit_rd_out(b_c_rd), .commit_data_out(b_c_data),
        .commit_tag_out(b_c_tag), .commit_store_out(b_c_store), .flush_out(b_fl),
        .flush_pc_out(b_fl_pc), .pred_valid_out(b_p_valid), .pred_taken_out(b_p_taken),
        .pred_pc_out(b_p_pc), .empty_out(b_empty), .count_out(b_count)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          st;
        logic          consec;
        logic          br;
        logic          tk;
        logic [31:0]   pc;
        logic          fl;
        logic [31:0]   fpc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_commit = -10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [TW-1:0] tag, input logic [4:0] rd, input logic [31:0] data,
                        input logic st, input logic consec, input logic br, input logic tk,
                        input logic [31:0] pc, input logic f, input logic [31:0] fpc);
        exp_t e;
        e.tag = tag; e.rd = rd; e.data = data; e.st = st; e.consec = consec;
        e.br = br; e.tk = tk; e.pc = pc; e.fl = f; e.fpc = fpc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_t(input logic [4:0] rd, input logic br, input logic st, input logic pt,
                           input logic [31:0] pc, input logic [31:0] rb, input logic [TW-1:0] et);
        a_rd = rd; a_br = br; a_st = st; a_pt = pt; a_pc = pc; a_rb = rb; a_valid = 1'b1;
        #1;
        chk("alloc_tag", 64'(a_tag), 64'(et));
        chk("alloc_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wb(input logic [1:0] v, input logic [TW-1:0] t0, input logic [31:0] d0,
                      input logic k0, input logic [TW-1:0] t1, input logic [31:0] d1,
                      input logic k1);
        wb_v = v; wb_t = {t1, t0}; wb_d = {d1, d0}; wb_k = {k1, k0};
        tick();
        wb_v = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Commit monitor: every retirement must match the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (fl && !c_valid) chk("flush_without_commit", 64'(fl), 64'd0);
            if (c_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_commit: got commit tag %0d, required no commit", c_tag);
                end else begin
                    e = sb.pop_front();
                    chk("commit_tag", 64'(c_tag), 64'(e.tag));
                    chk("commit_rd", 64'(c_rd), 64'(e.rd));
                    chk("commit_data", 64'(c_data), 64'(e.data));
                    chk("commit_store", 64'(c_store), 64'(e.st));
                    chk("pred_valid", 64'(p_valid), 64'(e.br));
                    if (e.br) begin
                        chk("pred_taken", 64'(p_taken), 64'(e.tk));
                        chk("pred_pc", 64'(p_pc), 64'(e.pc));
                    end
                    chk("flush", 64'(fl), 64'(e.fl));
                    if (e.fl) chk("flush_pc", 64'(fl_pc), 64'(e.fpc));
                    if (e.consec) chk("commit_spacing", 64'(cyc - last_commit), 64'd1);
                    last_commit = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; b_rst_n = 1'b0; rdy = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_rd = '0; a_br = 1'b0; a_st = 1'b0; a_pt = 1'b0;
        a_pc = '0; a_rb = '0; q1_tag = '0; q2_tag = '0; b_q_tag = '0;
        wb_v = '0; wb_t = '0; wb_d = '0; wb_k = '0; b_wb_v = '0; b_wb_t = '0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_alloc_ready", 64'(a_ready), 64'd1);
        chk("rst_alloc_tag", 64'(a_tag), 64'd0);
        chk("rst_commit_valid", 64'(c_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-operation on the deeper instance.
        b_valid = 1'b1;
        repeat (5) tick();
        b_valid = 1'b0;
        chk("big_count_filled", 64'(b_count), 64'd5);
        #2 b_rst_n = 1'b0;
        #1;
        chk("big_rst_count", 64'(b_count), 64'd0);
        chk("big_rst_empty", 64'(b_empty), 64'd1);
        chk("big_rst_pulses", 64'({b_c_valid, b_fl, b_p_valid}), 64'd0);
        chk("big_rst_tag", 64'(b_tag), 64'd0);
        b_rst_n = 1'b1;

        // Fill to full, retire in order, then wrap.
        alloc_t(5'd1, 0, 0, 0, 32'h100, 32'h0, 2'd0);
        alloc_t(5'd2, 0, 0, 0, 32'h104, 32'h0, 2'd1);
        alloc_t(5'd3, 0, 1, 0, 32'h108, 32'h0, 2'd2);
        alloc_t(5'd4, 0, 0, 0, 32'h10C, 32'h0, 2'd3);
        chk("full_ready", 64'(a_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        push(2'd0, 5'd1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        push(2'd1, 5'd2, 32'h11, 0, 1, 0, 0, 0, 0, 0);
        push(2'd2, 5'd3, 32'h12, 1, 1, 0, 0, 0, 0, 0);
        push(2'd3, 5'd4, 32'h13, 0, 1, 0, 0, 0, 0, 0);
        wb(2'b11, 2'd0, 32'h10, 0, 2'd1, 32'h11, 0);
        wb(2'b11, 2'd2, 32'h12, 0, 2'd3, 32'h13, 0);
        drain("fill_drain");
        chk("fill_empty", 64'(empty), 64'd1);
        alloc_t(5'd12, 0, 0, 0, 32'h200, 32'h0, 2'd0);
        alloc_t(5'd13, 0, 0, 0, 32'h204, 32'h0, 2'd1);
        push(2'd0, 5'd12, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        push(2'd1, 5'd13, 32'h21, 0, 1, 0, 0, 0, 0, 0);
        wb(2'b11, 2'd0, 32'h20, 0, 2'd1, 32'h21, 0);
        drain("wrap_drain");

        // Out-of-order writeback: youngest first, nothing retires until the head is ready.
        alloc_t(5'd14, 0, 0, 0, 32'h300, 32'h0, 2'd2);
        alloc_t(5'd15, 0, 0, 0, 32'h304, 32'h0, 2'd3);
        alloc_t(5'd16, 0, 0, 0, 32'h308, 32'h0, 2'd0);
        wb(2'b01, 2'd0, 32'h30, 0, 2'd0, 32'h0, 0);
        wb(2'b10, 2'd0, 32'h0, 0, 2'd3, 32'h31, 0);
        chk("ooo_no_commit_count", 64'(count), 64'd3);
        push(2'd2, 5'd14, 32'h32, 0, 0, 0, 0, 0, 0, 0);
        push(2'd3, 5'd15, 32'h31, 0, 1, 0, 0, 0, 0, 0);
        push(2'd0, 5'd16, 32'h30, 0, 1, 0, 0, 0, 0, 0);
        wb(2'b01, 2'd2, 32'h32, 0, 2'd0, 32'h0, 0);
        drain("ooo_drain");

        // Forwarding with both channels on the same tag: channel 0 wins.
        alloc_t(5'd5, 0, 0, 0, 32'h400, 32'h0, 2'd1);
        alloc_t(5'd6, 0, 0, 0, 32'h404, 32'h0, 2'd2);
        alloc_t(5'd7, 0, 0, 0, 32'h408, 32'h0, 2'd3);
        wb_v = 2'b11; wb_t = {2'd3, 2'd3}; wb_d = {32'hBB, 32'hAA}; wb_k = '0;
        q1_tag = 2'd3; q2_tag = 2'd2;
        #1;
        chk("fwd_q1_ready", 64'(q1_rdy), 64'd1);
        chk("fwd_q1_data", 64'(q1_data), 64'hAA);
        chk("fwd_q2_not_ready", 64'(q2_rdy), 64'd0);
        tick();
        wb_v = '0;
        #1;
        chk("reg_q1_ready", 64'(q1_rdy), 64'd1);
        chk("reg_q1_data", 64'(q1_data), 64'hAA);
        push(2'd1, 5'd5, 32'h41, 0, 0, 0, 0, 0, 0, 0);
        push(2'd2, 5'd6, 32'h42, 0, 1, 0, 0, 0, 0, 0);
        push(2'd3, 5'd7, 32'hAA, 0, 1, 0, 0, 0, 0, 0);
        wb(2'b11, 2'd1, 32'h41, 0, 2'd2, 32'h42, 0);
        drain("fwd_drain");

        // Mispredicted branch with three younger entries in flight.
        alloc_t(5'd0, 1, 0, 0, 32'h0F00, 32'h1000, 2'd0);
        alloc_t(5'd8, 0, 0, 0, 32'h0F04, 32'h0, 2'd1);
        alloc_t(5'd9, 0, 0, 0, 32'h0F08, 32'h0, 2'd2);
        alloc_t(5'd10, 0, 0, 0, 32'h0F0C, 32'h0, 2'd3);
        push(2'd0, 5'd0, 32'h0, 0, 0, 1, 1, 32'h0F00, 1, 32'h1000);
        wb(2'b11, 2'd1, 32'h51, 0, 2'd0, 32'h0, 1);
        tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_alloc_ready", 64'(a_ready), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        tick();
        chk("post_flush_ready", 64'(a_ready), 64'd1);

        // Allocation attempted on the flush edge is dropped.
        alloc_t(5'd17, 1, 0, 1, 32'h2F00, 32'h2000, 2'd0);
        alloc_t(5'd18, 0, 0, 0, 32'h2F04, 32'h0, 2'd1);
        push(2'd0, 5'd17, 32'h99, 0, 0, 1, 0, 32'h2F00, 1, 32'h2000);
        wb(2'b01, 2'd0, 32'h99, 0, 2'd0, 32'h0, 0);
        a_rd = 5'd19; a_br = 1'b0; a_valid = 1'b1;
        #1;
        chk("flush_edge_alloc_ready", 64'(a_ready), 64'd1);
        chk("flush_edge_alloc_tag", 64'(a_tag), 64'd2);
        tick();
        a_valid = 1'b0;
        chk("dropped_alloc_count", 64'(count), 64'd0);
        chk("dropped_alloc_tag", 64'(a_tag), 64'd0);
        tick();

        // rdy_in stall holds a ready head and ignores allocation.
        alloc_t(5'd11, 0, 1, 0, 32'h500, 32'h0, 2'd0);
        wb(2'b01, 2'd0, 32'h77, 0, 2'd0, 32'h0, 0);
        rdy = 1'b0;
        a_rd = 5'd20; a_valid = 1'b1;
        repeat (3) tick();
        a_valid = 1'b0;
        chk("stall_count", 64'(count), 64'd1);
        chk("stall_tag", 64'(a_tag), 64'd1);
        rdy = 1'b1;
        push(2'd0, 5'd11, 32'h77, 1, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        chk("stall_commit_first_edge", 64'(sb.size()), 64'd0);
        chk("stall_final_count", 64'(count), 64'd0);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
